// File: rtl/pe_load_scheduler.sv
// Load/compute scheduler for one PE: steers depacketized words into the filter and
// ifmap scratchpads and launches one compute once a full filter and ifmap set are loaded.
module pe_load_scheduler #(
    parameter int DATA_WIDTH  = 24,
    parameter int FILTER_ROWS = 3,
    parameter int IFMAP_WORDS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [1:0]            in_filter_row,
    input  logic                  in_ifmapb_filter,
    input  logic                  in_timestep,
    output logic                  filt_we,
    output logic [1:0]            filt_addr,
    output logic [DATA_WIDTH-1:0] filt_wdata,
    output logic                  ifm_we,
    output logic [1:0]            ifm_addr,
    output logic [DATA_WIDTH-1:0] ifm_wdata,
    output logic                  start,
    output logic                  start_timestep,
    input  logic                  done,
    output logic                  busy,
    output logic                  err_row,
    output logic                  err_ts
);
    localparam logic [2:0] ROW_LIMIT = 3'(FILTER_ROWS);
    localparam logic [2:0] IFM_FULL  = 3'(IFMAP_WORDS);
    localparam logic [3:0] ROW_ALL   = 4'((1 << FILTER_ROWS) - 1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_ARM   = 2'd1,
        ST_START = 2'd2,
        ST_WAIT  = 2'd3
    } state_e;

    state_e                state_q;
    logic [3:0]            filt_mask_q, filt_mask_d;
    logic [2:0]            ifm_cnt_q, ifm_cnt_d;
    logic                  exp_ts_q;
    logic                  filt_we_q, ifm_we_q, start_q, start_ts_q, busy_q;
    logic                  err_row_q, err_ts_q;
    logic [1:0]            filt_addr_q, ifm_addr_q;
    logic [DATA_WIDTH-1:0] filt_wdata_q, ifm_wdata_q;

    logic accept_s, filt_ok_s, row_bad_s, ifm_ok_s, ts_bad_s, load_full_s;

    assign in_ready = (state_q == ST_LOAD);
    assign accept_s = in_valid && in_ready;

    // Classify an accepted word: buffer write, error drop, or silent drop when the ifmap set is full.
    always_comb begin
        filt_ok_s = 1'b0;
        row_bad_s = 1'b0;
        ifm_ok_s  = 1'b0;
        ts_bad_s  = 1'b0;
        if (accept_s) begin
            if (in_ifmapb_filter) begin
                if ({1'b0, in_filter_row} < ROW_LIMIT) begin
                    filt_ok_s = 1'b1;
                end else begin
                    row_bad_s = 1'b1;
                end
            end else if (in_timestep != exp_ts_q) begin
                ts_bad_s = 1'b1;
            end else if (ifm_cnt_q < IFM_FULL) begin
                ifm_ok_s = 1'b1;
            end else begin
                ifm_ok_s = 1'b0;
            end
        end else begin
            filt_ok_s = 1'b0;
        end
    end

    // Post-accept view of the load progress; the completing word itself may trigger arming.
    always_comb begin
        filt_mask_d = filt_mask_q;
        ifm_cnt_d   = ifm_cnt_q;
        if (filt_ok_s) begin
            filt_mask_d = filt_mask_q | (4'b0001 << in_filter_row);
        end else begin
            filt_mask_d = filt_mask_q;
        end
        if (ifm_ok_s) begin
            ifm_cnt_d = ifm_cnt_q + 3'd1;
        end else begin
            ifm_cnt_d = ifm_cnt_q;
        end
    end

    assign load_full_s = ((filt_mask_d & ROW_ALL) == ROW_ALL) && (ifm_cnt_d == IFM_FULL);

    // Scheduler state machine with registered write strobes, launch pulse and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_LOAD;
            filt_mask_q  <= 4'd0;
            ifm_cnt_q    <= 3'd0;
            exp_ts_q     <= 1'b0;
            filt_we_q    <= 1'b0;
            filt_addr_q  <= 2'd0;
            filt_wdata_q <= {DATA_WIDTH{1'b0}};
            ifm_we_q     <= 1'b0;
            ifm_addr_q   <= 2'd0;
            ifm_wdata_q  <= {DATA_WIDTH{1'b0}};
            start_q      <= 1'b0;
            start_ts_q   <= 1'b0;
            busy_q       <= 1'b0;
            err_row_q    <= 1'b0;
            err_ts_q     <= 1'b0;
        end else begin
            filt_we_q  <= filt_ok_s;
            ifm_we_q   <= ifm_ok_s;
            if (filt_ok_s) begin
                filt_addr_q  <= in_filter_row;
                filt_wdata_q <= in_data;
            end
            if (ifm_ok_s) begin
                ifm_addr_q  <= ifm_cnt_q[1:0];
                ifm_wdata_q <= in_data;
            end
            err_row_q  <= err_row_q | row_bad_s;
            err_ts_q   <= err_ts_q | ts_bad_s;
            start_q    <= 1'b0;
            start_ts_q <= 1'b0;
            case (state_q)
                ST_LOAD: begin
                    filt_mask_q <= filt_mask_d;
                    ifm_cnt_q   <= ifm_cnt_d;
                    if (load_full_s) begin
                        state_q <= ST_ARM;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_LOAD;
                        busy_q  <= 1'b0;
                    end
                end
                // One idle cycle so the final buffer write lands before the engine starts.
                ST_ARM: begin
                    state_q    <= ST_START;
                    start_q    <= 1'b1;
                    start_ts_q <= exp_ts_q;
                    busy_q     <= 1'b1;
                end
                ST_START: begin
                    state_q <= ST_WAIT;
                    busy_q  <= 1'b1;
                end
                ST_WAIT: begin
                    if (done) begin
                        state_q   <= ST_LOAD;
                        ifm_cnt_q <= 3'd0;
                        exp_ts_q  <= ~exp_ts_q;
                        busy_q    <= 1'b0;
                    end else begin
                        state_q <= ST_WAIT;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_LOAD;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign filt_we        = filt_we_q;
    assign filt_addr      = filt_addr_q;
    assign filt_wdata     = filt_wdata_q;
    assign ifm_we         = ifm_we_q;
    assign ifm_addr       = ifm_addr_q;
    assign ifm_wdata      = ifm_wdata_q;
    assign start          = start_q;
    assign start_timestep = start_ts_q;
    assign busy           = busy_q;
    assign err_row        = err_row_q;
    assign err_ts         = err_ts_q;

endmodule

// File: doc/pe_load_scheduler.md
# pe_load_scheduler

Clocked load/compute scheduler for one PE. Sits between the packet depacketizer and the PE's filter/ifmap scratchpads plus MAC engine. Accepts depacketized words (data, filter_row, ifmap/filter select, timestep) and steers each into the filter or ifmap buffer. Once the filter is complete and a full ifmap set for the expected timestep has arrived, it issues one start pulse and blocks input until the engine reports done.

## Interface
Parameters:
- DATA_WIDTH, 24, payload width of one word
- FILTER_ROWS, 3, filter rows required before compute (1..4)
- IFMAP_WORDS, 3, ifmap words per timestep (1..4)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  depacketized word present
- in_ready  out  1  block accepts word; transfer when in_valid && in_ready at a rising edge
- in_data  in  DATA_WIDTH  payload
- in_filter_row  in  2  filter row index (filter words only)
- in_ifmapb_filter  in  1  0 = ifmap word, 1 = filter word
- in_timestep  in  1  timestep tag of the word
- filt_we  out  1  filter buffer write strobe
- filt_addr  out  2  filter row written
- filt_wdata  out  DATA_WIDTH  filter write data
- ifm_we  out  1  ifmap buffer write strobe
- ifm_addr  out  2  ifmap slot written
- ifm_wdata  out  DATA_WIDTH  ifmap write data
- start  out  1  one-cycle compute launch
- start_timestep  out  1  timestep of the launched compute
- done  in  1  compute finished (single-cycle pulse)
- busy  out  1  state != LOAD
- err_row  out  1  sticky: filter row >= FILTER_ROWS received
- err_ts  out  1  sticky: ifmap word with wrong timestep received

## Operation
- States: LOAD, ARM, START, WAIT. Reset state is LOAD.
- in_ready = (state == LOAD). This is combinational from the state register only.
- Filter word accepted:
  - If row < FILTER_ROWS: write row, set filt_mask[row]. Rewriting a row overwrites the data; the mask bit stays set.
  - Otherwise: drop the word and set err_row.
- Ifmap word accepted:
  - If in_timestep == exp_ts: write to slot ifm_cnt, then ifm_cnt++.
  - Otherwise: drop the word and set err_ts.
- ifm_cnt saturates at IFMAP_WORDS. Ifmap words accepted while ifm_cnt == IFMAP_WORDS are dropped without error.
- LOAD -> ARM at the edge where the resulting state has filt_mask all-ones over FILTER_ROWS and ifm_cnt == IFMAP_WORDS. This includes the edge that accepts the completing word.
- ARM -> START after 1 cycle. This lets the final buffer write land first.
- START: start = 1 and start_timestep = exp_ts for exactly 1 cycle, then -> WAIT.
- WAIT: on done = 1:
  - ifm_cnt <= 0
  - exp_ts <= ~exp_ts
  - state -> LOAD
- Filter persistence: filt_mask and the filter contents persist across timesteps. Only rst clears filt_mask.
- done outside WAIT is ignored.
- Reset (at any state, including mid-WAIT) returns to LOAD and clears all state. The engine is not notified; it must itself be reset.
- Reset values: state = LOAD, filt_mask = 0, ifm_cnt = 0, exp_ts = 0, and all outputs 0, except in_ready = 1.

## Timing
- All outputs except in_ready are registered.
- Write strobes (filt_we/ifm_we, with addr/wdata) are high in the cycle after the accepting edge, for 1 cycle.
- Back-to-back acceptance gives continuous strobes, one word per cycle.
- Last qualifying word accepted at edge k:
  - in_ready = 0 after edge k
  - write strobe during cycle k+1
  - start = 1 during cycle k+2 (after edge k+1)
  - WAIT from edge k+2
- done sampled at edge d: in_ready = 1 after edge d. The earliest next acceptance is edge d+1.
- Dropped words still complete the handshake. They produce no write strobe and no counter change.
- Sticky error flags assert after the accepting edge and clear only on rst.

## Test plan
- Reset, then send filter rows 0, 1, 2 (data 0x000011/22/33), then 3 ifmap words with ts=0 (0xA0/A1/A2). Required:
  - filt_we at addrs 0/1/2 and ifm_we at addrs 0/1/2 with matching data.
  - start pulses 2 cycles after the last accept, with start_timestep = 0.
  - in_ready stays 0 until done.
- After test 1, pulse done, then send 3 ifmap words with ts=1 and no filter words. Required: start with start_timestep = 1, and filt_mask is retained.
- Send an ifmap word with ts=1 while exp_ts = 0. Required: handshake completes, no ifm_we, err_ts = 1, ifm_cnt unchanged.
- Send a filter word with row 3 when FILTER_ROWS = 3. Required: no filt_we, err_row = 1, no start even after all ifmap words arrive.
- Send ifmap words first, then filter rows 2, 0, 1. Required: start only after row 1 is accepted. Done pulsed in LOAD/START is ignored.
- Assert rst during WAIT. Required:
  - in_ready = 1, busy = 0, errors cleared.
  - A full reload is needed before the next start, with start_timestep = 0.
